// File: rtl/stream_pkg.sv
// Shared stream types: lane/width constants and the tagged beat held in the output slot.
package stream_pkg;
  localparam int STREAM_WIDTH = 8;
  localparam int STREAM_LANES = 4;

  typedef logic [1:0] lane_idx_t;

  typedef struct packed {
    logic [STREAM_WIDTH-1:0] bits;
    lane_idx_t               idx;
  } tagged_beat_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant_onehot,
  output logic [IW-1:0] grant_idx,
  output logic          any
);
  always_comb begin
    grant_idx    = '0;
    any          = 1'b0;
    grant_onehot = '0;
    // Walk offsets from farthest to nearest so the lane closest to ptr wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[ptr + IW'(i)]) begin
        grant_idx = ptr + IW'(i);
        any       = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      grant_onehot[j] = any && (grant_idx == IW'(j));
    end
  end
endmodule

// File: rtl/stream_collector.sv
// Four-to-one round-robin stream merger with a one-entry tagged output slot and beat counter.
module stream_collector
  import stream_pkg::*;
#(
  parameter int WIDTH = STREAM_WIDTH,
  parameter int N     = STREAM_LANES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_0_valid,
  output logic             io_in_0_ready,
  input  logic [WIDTH-1:0] io_in_0_bits,
  input  logic             io_in_1_valid,
  output logic             io_in_1_ready,
  input  logic [WIDTH-1:0] io_in_1_bits,
  input  logic             io_in_2_valid,
  output logic             io_in_2_ready,
  input  logic [WIDTH-1:0] io_in_2_bits,
  input  logic             io_in_3_valid,
  output logic             io_in_3_ready,
  input  logic [WIDTH-1:0] io_in_3_bits,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_bits,
  output logic [1:0]       io_out_idx,
  output logic [31:0]      io_count
);
  logic [N-1:0]     valid_vec;
  logic [N-1:0]     grant_onehot;
  logic [N-1:0]     ready_vec;
  logic [WIDTH-1:0] lane_bits [N];
  lane_idx_t        grant_idx;
  logic             grant_any;
  logic             free;
  logic             accept;

  tagged_beat_t slot_reg;
  logic         full_reg;
  lane_idx_t    ptr_reg;
  logic [31:0]  count_reg;

  assign valid_vec    = {io_in_3_valid, io_in_2_valid, io_in_1_valid, io_in_0_valid};
  assign lane_bits[0] = io_in_0_bits;
  assign lane_bits[1] = io_in_1_bits;
  assign lane_bits[2] = io_in_2_bits;
  assign lane_bits[3] = io_in_3_bits;

  rr_arbiter #(.N(N)) u_arb (
    .req          (valid_vec),
    .ptr          (ptr_reg),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any          (grant_any)
  );

  // The slot can refill on the same edge it drains; reset masks readies so nothing is taken.
  assign free      = !full_reg || io_out_ready;
  assign accept    = free && grant_any && !reset;
  assign ready_vec = (free && !reset) ? grant_onehot : '0;

  assign io_in_0_ready = ready_vec[0];
  assign io_in_1_ready = ready_vec[1];
  assign io_in_2_ready = ready_vec[2];
  assign io_in_3_ready = ready_vec[3];

  assign io_out_valid = full_reg;
  assign io_out_bits  = slot_reg.bits;
  assign io_out_idx   = slot_reg.idx;
  assign io_count     = count_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_reg  <= '0;
      full_reg  <= 1'b0;
      ptr_reg   <= '0;
      count_reg <= '0;
    end else begin
      if (full_reg && io_out_ready) begin
        count_reg <= count_reg + 32'd1;
      end
      if (accept) begin
        slot_reg <= '{bits: lane_bits[grant_idx], idx: grant_idx};
        full_reg <= 1'b1;
        ptr_reg  <= grant_idx + 2'd1;
      end else if (io_out_ready) begin
        full_reg <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_stream_collector.sv
// Scoreboard bench for stream_collector: per-cycle reference model plus fixed expected sequences.
module tb_stream_collector;
  import stream_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  in_valid = 4'b0;
  logic [3:0]  in_ready;
  logic [7:0]  in_bits [4];
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [7:0]  out_bits;
  logic [1:0]  out_idx;
  logic [31:0] out_count;

  always #5 clock = ~clock;

  stream_collector dut (
    .clock         (clock),
    .reset         (reset),
    .io_in_0_valid (in_valid[0]),
    .io_in_0_ready (in_ready[0]),
    .io_in_0_bits  (in_bits[0]),
    .io_in_1_valid (in_valid[1]),
    .io_in_1_ready (in_ready[1]),
    .io_in_1_bits  (in_bits[1]),
    .io_in_2_valid (in_valid[2]),
    .io_in_2_ready (in_ready[2]),
    .io_in_2_bits  (in_bits[2]),
    .io_in_3_valid (in_valid[3]),
    .io_in_3_ready (in_ready[3]),
    .io_in_3_bits  (in_bits[3]),
    .io_out_valid  (out_valid),
    .io_out_ready  (out_ready),
    .io_out_bits   (out_bits),
    .io_out_idx    (out_idx),
    .io_count      (out_count)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0]   lane_q [4][$];
  tagged_beat_t sb [$];
  tagged_beat_t out_log [$];
  logic         m_full = 1'b0;
  logic [1:0]   m_ptr = 2'd0;
  logic [31:0]  m_count = 32'd0;

  task automatic drive_inputs();
    for (int k = 0; k < 4; k++) begin
      in_valid[k] = (lane_q[k].size() > 0);
      in_bits[k]  = in_valid[k] ? lane_q[k][0] : 8'($urandom);
    end
  endtask

  // One clock: check DUT against the model mid-cycle, then advance the model at the edge.
  task automatic step();
    logic [3:0]   exp_ready;
    logic [1:0]   g;
    logic [1:0]   k;
    logic         any;
    logic         free;
    tagged_beat_t t;
    @(negedge clock);
    drive_inputs();
    #1;
    any = 1'b0;
    g   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      k = m_ptr + 2'(i);
      if (in_valid[k]) begin
        g   = k;
        any = 1'b1;
      end
    end
    free      = !m_full || out_ready;
    exp_ready = (!reset && free && any) ? (4'b0001 << g) : 4'b0000;
    tests++;
    if (in_ready !== exp_ready) begin
      fails++;
      $display("FAIL ready: got %b expected %b at %0t", in_ready, exp_ready, $time);
    end
    tests++;
    if (out_valid !== m_full) begin
      fails++;
      $display("FAIL out_valid: got %b expected %b at %0t", out_valid, m_full, $time);
    end
    if (m_full && sb.size() > 0) begin
      tests++;
      if (out_bits !== sb[0].bits || out_idx !== sb[0].idx) begin
        fails++;
        $display("FAIL out_beat: got %h/%0d expected %h/%0d at %0t",
                 out_bits, out_idx, sb[0].bits, sb[0].idx, $time);
      end
    end
    tests++;
    if (out_count !== m_count) begin
      fails++;
      $display("FAIL count: got %0d expected %0d at %0t", out_count, m_count, $time);
    end
    @(posedge clock);
    if (reset) begin
      m_full  = 1'b0;
      m_ptr   = 2'd0;
      m_count = 32'd0;
      sb.delete();
    end else begin
      if (m_full && out_ready) begin
        out_log.push_back(sb.pop_front());
        m_count++;
      end
      if (free && any) begin
        t.bits = in_bits[g];
        t.idx  = g;
        sb.push_back(t);
        void'(lane_q[g].pop_front());
        m_ptr  = g + 2'd1;
        m_full = 1'b1;
      end else if (out_ready) begin
        m_full = 1'b0;
      end
    end
    $display("[TB] t=%0t rdy=%b out_v=%b bits=%h idx=%0d cnt=%0d",
             $time, in_ready, out_valid, out_bits, out_idx, out_count);
    #1;
  endtask

  task automatic clear_lanes();
    for (int k = 0; k < 4; k++) lane_q[k].delete();
    out_log.delete();
  endtask

  task automatic do_reset();
    clear_lanes();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic check_fair_log(input int beats, input string name);
    tests++;
    if (out_log.size() != beats) begin
      fails++;
      $display("FAIL %s_len: got %0d expected %0d", name, out_log.size(), beats);
    end
    for (int i = 0; i < out_log.size() && i < beats; i++) begin
      tests++;
      if (out_log[i].idx !== 2'(i % 4) || out_log[i].bits !== 8'(16 * (i % 4) + i / 4)) begin
        fails++;
        $display("FAIL %s_beat%0d: got %h/%0d expected %h/%0d", name, i,
                 out_log[i].bits, out_log[i].idx, 8'(16 * (i % 4) + i / 4), i % 4);
      end
    end
  endtask

  task automatic test_reset();
    clear_lanes();
    reset     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) lane_q[k].push_back(8'(8'hA0 + k));
    repeat (100) step();
    reset = 1'b0;
    repeat (6) step();
    tests++;
    if (out_log.size() != 4) begin
      fails++;
      $display("FAIL reset_len: got %0d expected 4", out_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (out_log[i].idx !== 2'(i) || out_log[i].bits !== 8'(8'hA0 + i)) begin
          fails++;
          $display("FAIL reset_order%0d: got %h/%0d expected %h/%0d", i,
                   out_log[i].bits, out_log[i].idx, 8'(8'hA0 + i), i);
        end
      end
    end
  endtask

  task automatic test_single_lane();
    do_reset();
    out_ready = 1'b1;
    for (int n = 0; n < 16; n++) lane_q[2].push_back(8'(n));
    repeat (18) step();
    tests++;
    if (out_log.size() != 16) begin
      fails++;
      $display("FAIL single_len: got %0d expected 16", out_log.size());
    end
    for (int i = 0; i < out_log.size() && i < 16; i++) begin
      tests++;
      if (out_log[i].bits !== 8'(i) || out_log[i].idx !== 2'd2) begin
        fails++;
        $display("FAIL single_beat%0d: got %h/%0d expected %h/2", i,
                 out_log[i].bits, out_log[i].idx, 8'(i));
      end
    end
    tests++;
    if (out_count !== 32'd16) begin
      fails++;
      $display("FAIL single_count: got %0d expected 16", out_count);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++)
      for (int n = 0; n < 8; n++) lane_q[k].push_back(8'(16 * k + n));
    repeat (34) step();
    check_fair_log(32, "fair");
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++)
      for (int n = 0; n < 5; n++) lane_q[k].push_back(8'(16 * k + n));
    repeat (6) step();
    out_ready = 1'b0;
    repeat (100) step();
    out_ready = 1'b1;
    repeat (20) step();
    check_fair_log(20, "bp");
  endtask

  task automatic test_drain_accept();
    int ones;
    do_reset();
    for (int k = 0; k < 4; k++)
      for (int n = 0; n < 8; n++) lane_q[k].push_back(8'(16 * k + n));
    out_ready = 1'b1;
    step();
    ones = 0;
    for (int c = 0; c < 20; c++) begin
      out_ready = (c % 2 == 0);
      if (out_ready) ones++;
      step();
      tests++;
      if (out_valid !== 1'b1) begin
        fails++;
        $display("FAIL drain_full%0d: got %b expected 1", c, out_valid);
      end
    end
    tests++;
    if (out_count !== 32'(ones)) begin
      fails++;
      $display("FAIL drain_count: got %0d expected %0d", out_count, ones);
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    out_ready = 1'b1;
    for (int n = 1; n <= 3; n++) lane_q[0].push_back(8'(n));
    repeat (4) step();
    out_ready = 1'b0;
    lane_q[1].push_back(8'h55);
    repeat (2) step();
    tests++;
    if (out_bits !== 8'h55 || out_count !== 32'd3) begin
      fails++;
      $display("FAIL midop_hold: got %h cnt %0d expected 55 cnt 3", out_bits, out_count);
    end
    reset = 1'b1;
    repeat (2) step();
    reset     = 1'b0;
    out_ready = 1'b1;
    repeat (5) step();
    tests++;
    if (out_count !== 32'd0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL midop_reset: got cnt %0d valid %b expected 0 0", out_count, out_valid);
    end
    foreach (out_log[i]) begin
      tests++;
      if (out_log[i].bits === 8'h55) begin
        fails++;
        $display("FAIL midop_leak: got 55 at log %0d expected none", i);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) in_bits[k] = 8'h00;
    test_reset();
    test_single_lane();
    test_fairness();
    test_backpressure();
    test_drain_accept();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/stream_collector.md
# stream_collector

Merges four independent ready/valid byte streams into one output stream. It is the many-to-one counterpart of the one-to-four ProducerConsumer distributor: each result lane a distributor fans out can be gathered back into a single ordered stream. Arbitration is round-robin. Each accepted beat passes through a one-entry output register tagged with its source lane. The block also keeps a running count of delivered beats.

## Interface
- `WIDTH`, 8: data width of every lane, in bits.
- `N`, 4: number of input lanes. Fixed at 4; the port list below is written out for N=4.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `io_in_k_valid`  in  1  lane k (k=0..3) offers a beat.
- `io_in_k_ready`  out  1  lane k beat is accepted this cycle.
- `io_in_k_bits`  in  WIDTH  lane k data.
- `io_out_valid`  out  1  the output register holds a beat.
- `io_out_ready`  in  1  downstream accepts the output beat.
- `io_out_bits`  out  WIDTH  output data.
- `io_out_idx`  out  2  source lane of the output beat.
- `io_count`  out  32  beats delivered on the output since reset; wraps modulo 2^32.

## Operation
- **Handshake rule.** A beat transfers on any interface when valid and ready are both 1 at a rising edge.
- **Output slot.** One register holds `{bits, idx}` plus a `full` flag. `io_out_valid` = `full`.
- **Slot free.** The slot can take a new beat when `free` = `!full || io_out_ready`.
- **Round-robin pointer.** `ptr` is 2 bits.
  - Lanes are searched in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - The first lane with valid=1 is the grant `g`.
- **Ready.** `io_in_k_ready` = `free && (k == g)`, and is 0 when no lane is valid.
  - At most one ready is high per cycle.
  - A lane's ready depends combinationally on all valids, `ptr`, `full` and `io_out_ready`.
  - Lanes must not make valid depend on ready.
- **Accepting lane g.**
  - The slot loads `io_in_g_bits` and idx=g; `full` becomes 1.
  - `ptr` becomes g+1 mod 4, so lane 3 wraps to lane 0.
- **Output drained, no accept.** `full` becomes 0; bits and idx hold their last values.
- **Drain and accept in the same cycle.** The slot reloads and `full` stays 1.
- **Blocked downstream.** With `full=1` and `io_out_ready=0`:
  - all input readies are 0;
  - bits and idx are held stable;
  - `ptr` does not change.
- **Beat counter.** `io_count` increments by 1 on every output transfer and wraps from 0xFFFFFFFF to 0.
- **Lane contract.** A lane may hold valid with changing bits; only the value present at its transfer edge is captured.

## Timing
- **Reset values.**
  - Internal: `full`=0, `ptr`=0, slot bits=0, slot idx=0.
  - Outputs: `io_out_valid`=0, `io_out_bits`=0, `io_out_idx`=0, `io_count`=0, all `io_in_k_ready`=0.
- **Readies during reset.** All `io_in_k_ready` are forced to 0 while `reset` is high.
- **Reset mid-operation.** A beat held in the slot is discarded, not delivered, and not counted.
- **Latency.** A beat accepted at edge t appears with `io_out_valid`=1 in the cycle after t. It can leave at edge t+1 at the earliest.
- **Throughput.** With `io_out_ready` held high, one beat moves per cycle with no bubbles, sustained.
- **Fairness.** With all four lanes continuously valid, grants run 0,1,2,3,0,... Any valid lane is served within 4 accepted beats.
- **Idle cycles.** A cycle with no valid lane grants nothing and leaves `ptr` unchanged.

## Structure
- **Shared package `stream_pkg`.**
  - `STREAM_WIDTH`=8 and `STREAM_LANES`=4, shared with the distributor.
  - `lane_idx_t`, a 2-bit typedef.
  - `tagged_beat_t`, a struct `{bits, idx}`.
- **Sub-module `rr_arbiter`.**
  - Interface: parameter `N`; inputs `req[N-1:0]`, `ptr`; outputs `grant_onehot`, `grant_idx`, `any`.
  - Purely combinational.
  - `stream_collector` instantiates it and owns `ptr` and all other registers.

## Test plan
- **Reset.** Hold `reset` 100 cycles with all lanes valid → all readies 0, `io_out_valid`=0, `io_count`=0. Release → lane 0 is accepted first.
- **Single lane.** Lane 2 writes 0x00..0x0F with `io_out_ready`=1 → output bits 0x00..0x0F in order, idx=2 throughout, one beat per cycle, `io_count`=16.
- **Four-lane fairness.** All lanes valid; lane k sends 0x10·k+n → output idx sequence 0,1,2,3 repeating, bits 0x00,0x10,0x20,0x30,0x01,... with no gaps.
- **Backpressure.** Drop `io_out_ready` for 100 cycles mid-stream →
  - bits and idx stay stable;
  - input readies stay 0;
  - after release, the sequence resumes with no loss or duplication.
- **Drain and accept.** `io_out_ready` toggles 1,0,1,0 under full load → `full` never drops on drain-and-accept edges. Beats transferred = number of edges where `io_out_ready`=1.
- **Reset mid-operation.** Assert `reset` while the slot holds 0x55 → 0x55 never appears on the output, and `io_count` returns to 0.
